r_div_ctrl: RTL and testbench

Multicycle controller for the restoring divider in the PE divide functional unit. Accepts one dividend/divisor pair over a valid/ready handshake and iterates a single `r_div_stage` instance once per cycle, retiring `$clog2(RADIX)` quotient bits per cycle. Handles divide-by-zero and, optionally, signed operands. Returns quotient and remainder over a second valid/ready handshake to the PE result path.

---
 rtl/pea_pkg.sv | 29 ++
 rtl/r_div_stage.sv | 45 ++++
 rtl/r_div_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_r_div_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Purpose : shared PE-array constants and types used by the divide functional unit.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   N_BITS / N_RADIX : default datapath width and divider radix.
//   DIV_ITERS        : number of iteration cycles for the default divider build.
//   div_state_e      : divider controller FSM states.
//   div_cnt_w()      : width of the iteration counter for a given iteration count.
package pea_pkg;

  localparam int N_BITS    = 32;
  localparam int N_RADIX   = 4;
  localparam int DIV_ITERS = N_BITS / $clog2(N_RADIX);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  // A single-iteration divider still needs a 1-bit counter so that the
  // counter vector never collapses to zero width.
  function automatic int div_cnt_w(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/r_div_stage.sv
// Purpose : one radix-RADIX restoring-division step (LOG2R quotient bits per evaluation).
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   n_i : next LOG2R dividend bits, MSB first.
//   d_i : divisor magnitude (non-zero when the result is used).
//   r_i : partial remainder in, must satisfy r_i < d_i.
//   r_o : partial remainder out, r_o < d_i.
//   q_o : LOG2R quotient bits produced by this step.
module r_div_stage #(
  parameter int DATA_W = 32,
  parameter int LOG2R  = 2
) (
  input  logic [LOG2R-1:0]  n_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic [DATA_W-1:0] r_i,
  output logic [DATA_W-1:0] r_o,
  output logic [LOG2R-1:0]  q_o
);

  // One extra bit: since r < d before each shift, 2r+1 < 2d fits in DATA_W+1.
  logic [DATA_W:0]  acc;
  logic [DATA_W:0]  d_ext;
  logic [LOG2R-1:0] q_v;

  assign d_ext = {1'b0, d_i};

  always_comb begin
    acc = {1'b0, r_i};
    q_v = '0;
    for (int i = LOG2R - 1; i >= 0; i--) begin
      // acc[DATA_W] is always zero here, so dropping it on the shift is safe.
      acc = {acc[DATA_W-1:0], n_i[i]};
      if (acc >= d_ext) begin
        acc    = acc - d_ext;
        q_v[i] = 1'b1;
      end
    end
  end

  assign r_o = acc[DATA_W-1:0];
  assign q_o = q_v;

endmodule

// File: rtl/r_div_ctrl.sv
// Purpose : multicycle controller around one r_div_stage; returns quotient/remainder, flags divide-by-zero.
// Latency : ITERS+2 cycles from accept to valid_o (1 cycle for a zero divisor); one operation in flight.
// Backpressure: ready_o high only when idle; result held stable in DONE until ready_i.
//
// Optional feature macro: MAGE_DIV_SIGNED_EN adds the signed_i port and two's-complement handling.
//
// Ports:
//   clk_i, rst_n_i          : clock, synchronous active-low reset.
//   valid_i / ready_o       : operand handshake (dividend_i, divisor_i[, signed_i]).
//   flush_i                 : synchronous abort, returns to idle with no result.
//   valid_o / ready_i       : result handshake (quotient_o, remainder_o, div_by_zero_o).
module r_div_ctrl
  import pea_pkg::*;
#(
  parameter int DATA_W = N_BITS,
  parameter int RADIX  = N_RADIX
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
`ifdef MAGE_DIV_SIGNED_EN
  input  logic              signed_i,
`endif
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              div_by_zero_o
);

  localparam int LOG2R = $clog2(RADIX);
  localparam int ITERS = DATA_W / LOG2R;
  localparam int CNT_W = div_cnt_w(ITERS);

  div_state_e        state_q;
  div_state_e        state_d;

  logic [DATA_W-1:0] dvd_q;   // dividend magnitude, shifted left as bits are consumed
  logic [DATA_W-1:0] dsr_q;   // divisor magnitude
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dbz_q;
  logic              neg_q;   // quotient must be negated in FIX
  logic              neg_r;   // remainder must be negated in FIX

  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dsr_mag;
  logic              dsr_zero;
  logic              take;

  logic [LOG2R-1:0]  stage_q;
  logic [DATA_W-1:0] stage_r;

  // Handshake outputs depend on state only, never on valid_i/ready_i.
  assign ready_o  = (state_q == DIV_IDLE);
  assign valid_o  = (state_q == DIV_DONE);
  assign dsr_zero = (divisor_i == '0);

  // flush_i wins over an accept in the same cycle.
  assign take = ready_o && valid_i && !flush_i;

  // ------------------------------------------------------------------
  // Operand magnitudes and sign bookkeeping
  // ------------------------------------------------------------------
`ifdef MAGE_DIV_SIGNED_EN
  logic dvd_neg;
  logic dsr_neg;

  assign dvd_neg = signed_i && dividend_i[DATA_W-1];
  assign dsr_neg = signed_i && divisor_i[DATA_W-1];
  // MIN negates to itself; its unsigned magnitude 2^(DATA_W-1) is still correct.
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dsr_mag = dsr_neg ? -divisor_i  : divisor_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (take) begin
      neg_q <= dvd_neg ^ dsr_neg;
      neg_r <= dvd_neg;
    end
  end
`else
  assign dvd_mag = dividend_i;
  assign dsr_mag = divisor_i;
  // FIX still runs for one cycle so both builds share the same latency.
  assign neg_q   = 1'b0;
  assign neg_r   = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Single iteration stage
  // ------------------------------------------------------------------
  r_div_stage #(
    .DATA_W (DATA_W),
    .LOG2R  (LOG2R)
  ) u_stage (
    .n_i (dvd_q[DATA_W-1 -: LOG2R]),
    .d_i (dsr_q),
    .r_i (rem_q),
    .r_o (stage_r),
    .q_o (stage_q)
  );

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (valid_i) begin
          state_d = dsr_zero ? DIV_DONE : DIV_ITER;
        end
      end
      DIV_ITER: begin
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (ready_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = DIV_IDLE;
    end
  end

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dvd_q <= '0;
      dsr_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else if (!flush_i) begin
      case (state_q)
        DIV_IDLE: begin
          if (valid_i) begin
            dvd_q <= dvd_mag;
            dsr_q <= dsr_mag;
            cnt_q <= CNT_W'(ITERS - 1);
            if (dsr_zero) begin
              // Zero divisor: all-ones quotient, raw (un-negated) dividend as remainder.
              quo_q <= '1;
              rem_q <= dividend_i;
              dbz_q <= 1'b1;
            end else begin
              quo_q <= '0;
              rem_q <= '0;
              dbz_q <= 1'b0;
            end
          end
        end
        DIV_ITER: begin
          rem_q <= stage_r;
          dvd_q <= dvd_q << LOG2R;
          quo_q <= (quo_q << LOG2R) | DATA_W'(stage_q);
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DIV_FIX: begin
          quo_q <= neg_q ? -quo_q : quo_q;
          rem_q <= neg_r ? -rem_q : rem_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_r_div_ctrl.sv
// Purpose : self-checking bench for r_div_ctrl (DATA_W=32, RADIX=4, 18-cycle normal latency).
// Latency : n/a.
// Backpressure: exercised by holding ready_i low in DONE.
module tb_r_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signed_s;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dbz;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  r_div_ctrl #(
    .DATA_W (32),
    .RADIX  (4)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
`ifdef MAGE_DIV_SIGNED_EN
    .signed_i      (signed_s),
`endif
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dbz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: divide magnitudes, then apply signs (quotient sign = XOR, remainder sign = dividend).
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    logic        na, nb;
    logic [31:0] ma, mb, uq, ur;
    na = s && a[31];
    nb = s && b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      uq = ma / mb;
      ur = ma % mb;
      q  = (na ^ nb) ? -uq : uq;
      r  = na ? -ur : ur;
      z  = 1'b0;
    end
  endfunction

  // Presents one operand pair; returns at the negedge after the accept edge (cycle T+1).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    check("ready_before_accept", {31'd0, ready_o}, 32'd1);
    dividend = a;
    divisor  = b;
    signed_s = s;
    valid_i  = 1'b1;
    @(negedge clk);
    valid_i  = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    signed_s = 1'($urandom);
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = 1;
    while (!valid_o && lat < max) begin
      @(negedge clk);
      lat++;
    end
    if (!valid_o) begin
      total_cnt++;
      $display("FAIL valid_timeout: valid_o still low after %0d cycles, expected high", lat);
    end
  endtask

  // Full operation with ready_i high; checks latency, result and return to idle.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez);
    int lat;
    ready_i = 1'b1;
    start_op(a, b, s);
    wait_valid(40, lat);
    check({name, "_latency"}, 32'(lat), ez ? 32'd1 : 32'd18);
    check({name, "_quotient"}, quotient, eq);
    check({name, "_remainder"}, remainder, er);
    check({name, "_dbz"}, {31'd0, dbz}, {31'd0, ez});
    @(negedge clk);
    check({name, "_ready_after"}, {30'd0, ready_o, valid_o}, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eq, er, sq, sr;
    logic        ez, a_sig;
    logic [31:0] ra, rb;
    int          lat;
    int          saw;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,        1'b0});
    vecs.push_back('{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,     1'b1});
    vecs.push_back('{32'hFFFF_FFFF,  32'h10,         1'b0, 32'h0FFF_FFFF,  32'hF,        1'b0});
    vecs.push_back('{32'd10,         32'd3,          1'b0, 32'd3,          32'd1,        1'b0});
    vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,        1'b0});
    vecs.push_back('{32'd5,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd5,        1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,        1'b0});
    vecs.push_back('{32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd0,        1'b1});
    vecs.push_back('{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,        1'b0});
`ifdef MAGE_DIV_SIGNED_EN
    vecs.push_back('{-32'sd100,      32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{32'd100,        -32'sd7,        1'b1, 32'hFFFF_FFF2,  32'd2,        1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,        1'b0});
    vecs.push_back('{-32'sd5,        32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB, 1'b1});
`endif

    // Reset
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    flush_i  = 1'b0;
    dividend = '0;
    divisor  = '0;
    signed_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, ready_o}, 32'd1);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'd0, dbz}, 32'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
             vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'($urandom_range(1, 65535));
        default: rb = $urandom;
      endcase
`ifdef MAGE_DIV_SIGNED_EN
      a_sig = 1'($urandom);
`else
      a_sig = 1'b0;
`endif
      model(ra, rb, a_sig, eq, er, ez);
      run_op($sformatf("rand%0d", i), ra, rb, a_sig, eq, er, ez);
    end

    // Backpressure: hold result for 5 cycles while valid_i pulses with a zero divisor
    ready_i = 1'b0;
    start_op(32'd1000, 32'd9, 1'b0);
    wait_valid(40, lat);
    check("bp_latency", 32'(lat), 32'd18);
    check("bp_quotient", quotient, 32'd111);
    check("bp_remainder", remainder, 32'd1);
    sq = quotient;
    sr = remainder;
    for (int i = 0; i < 5; i++) begin
      valid_i  = ~i[0];
      dividend = $urandom;
      divisor  = 32'd0;
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), {30'd0, valid_o, ready_o}, 32'd2);
      check($sformatf("bp_hold_q%0d", i), quotient, sq);
      check($sformatf("bp_hold_r%0d", i), remainder, sr);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, ready_o, valid_o}, 32'd2);
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid_o) saw++;
    end
    check("bp_no_stray_accept", 32'(saw), 32'd0);

    // Flush at T+8: idle at T+9, no result ever
    start_op(32'hDEAD_BEEF, 32'h123, 1'b0);
    repeat (7) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_idle", {30'd0, ready_o, valid_o}, 32'd2);
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid_o) saw++;
    end
    check("flush_no_result", 32'(saw), 32'd0);
    run_op("after_flush", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);

    // Reset at T+5
    start_op(32'h89AB_CDEF, 32'h77, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_dbz", {31'd0, dbz}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, ready_o}, 32'd1);
    run_op("after_reset", 32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
